// File: rtl/parity_step_counter_pkg.sv
// Shared encodings and bound helpers for the parity step counter.
// Bounds are returned wide so callers can compare without overflow at WIDTH=32.
package parity_step_counter_pkg;

  typedef enum logic [1:0] {
    MODE_EVEN_UP   = 2'b00,
    MODE_ODD_UP    = 2'b01,
    MODE_EVEN_DOWN = 2'b10,
    MODE_ODD_DOWN  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic wrap;
    logic sat_hit;
  } step_flags_t;

  function automatic logic mode_is_odd(mode_e m);
    return (m == MODE_ODD_UP) || (m == MODE_ODD_DOWN);
  endfunction

  function automatic logic mode_is_down(mode_e m);
    return (m == MODE_EVEN_DOWN) || (m == MODE_ODD_DOWN);
  endfunction

  // Largest value of the target parity representable in w bits.
  function automatic logic [33:0] bound_hi(int unsigned w, logic odd);
    return (34'd1 << w) - (odd ? 34'd1 : 34'd2);
  endfunction

  function automatic logic [33:0] bound_lo(logic odd);
    return odd ? 34'd1 : 34'd0;
  endfunction

endpackage

// File: rtl/pcnt_next.sv
// Combinational next-count: one parity-aware step from the current value,
// flagging a wrap past the bound or a landing on the bound when saturating.
module pcnt_next
  import parity_step_counter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] cur,
  input  mode_e            mode,
  input  logic             sat,
  output logic [WIDTH-1:0] nxt,
  output step_flags_t      flags
);

  localparam int XW = WIDTH + 2;
  localparam logic [XW-1:0] HI_EVEN = XW'(bound_hi(WIDTH, 1'b0));
  localparam logic [XW-1:0] HI_ODD  = XW'(bound_hi(WIDTH, 1'b1));
  localparam logic [XW-1:0] LO_EVEN = XW'(bound_lo(1'b0));
  localparam logic [XW-1:0] LO_ODD  = XW'(bound_lo(1'b1));

  logic          odd, down;
  logic [XW-1:0] cur_x, stp, hi, lo, up_sum, dn_floor;

  always_comb begin
    odd      = mode_is_odd(mode);
    down     = mode_is_down(mode);
    cur_x    = XW'(cur);
    // Already on target parity: full step of 2; otherwise realign by 1.
    stp      = (cur[0] == odd) ? XW'(2) : XW'(1);
    hi       = odd ? HI_ODD : HI_EVEN;
    lo       = odd ? LO_ODD : LO_EVEN;
    up_sum   = cur_x + stp;
    dn_floor = lo + stp;
    nxt      = cur;
    flags    = '0;
    if (!down) begin
      if (sat && (up_sum >= hi)) begin
        nxt           = hi[WIDTH-1:0];
        flags.sat_hit = 1'b1;
      end else begin
        nxt        = up_sum[WIDTH-1:0];
        flags.wrap = (up_sum > hi);
      end
    end else begin
      // cur - stp <= lo rearranged to stay unsigned
      if (sat && (cur_x <= dn_floor)) begin
        nxt           = lo[WIDTH-1:0];
        flags.sat_hit = 1'b1;
      end else begin
        nxt        = cur - stp[WIDTH-1:0];
        flags.wrap = (cur_x < dn_floor);
      end
    end
  end

endmodule

// File: rtl/parity_step_counter.sv
// Parity-targeting up/down counter with wrap or saturate at the parity bound.
// Owns the count, WRAP pulse and the RUN/HOLD saturation FSM.
module parity_step_counter
  import parity_step_counter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             SAT,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] OUT,
  output logic             WRAP,
  output logic             SAT_HIT
);

  state_e           state_q, state_d;
  mode_e            mode, hold_mode_q, hold_mode_d;
  logic [WIDTH-1:0] out_d, step_val;
  logic             wrap_d, stepping;
  step_flags_t      flags;

  assign mode = mode_e'(MODE);

  pcnt_next #(.WIDTH(WIDTH)) u_next (
    .cur  (OUT),
    .mode (mode),
    .sat  (SAT),
    .nxt  (step_val),
    .flags(flags)
  );

  always_comb begin
    state_d     = state_q;
    hold_mode_d = hold_mode_q;
    out_d       = OUT;
    wrap_d      = 1'b0;
    // HOLD releases on a mode change or SAT drop and steps in that same cycle.
    stepping    = EN && ((state_q == ST_RUN) || (mode != hold_mode_q) || !SAT);
    if (LOAD) begin
      out_d   = LOAD_VAL;
      state_d = ST_RUN;
    end else if (stepping) begin
      out_d   = step_val;
      wrap_d  = flags.wrap;
      state_d = flags.sat_hit ? ST_HOLD : ST_RUN;
      if (flags.sat_hit) hold_mode_d = mode;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT         <= '0;
      WRAP        <= 1'b0;
      state_q     <= ST_RUN;
      hold_mode_q <= MODE_EVEN_UP;
    end else begin
      OUT         <= out_d;
      WRAP        <= wrap_d;
      state_q     <= state_d;
      hold_mode_q <= hold_mode_d;
    end
  end

  assign SAT_HIT = (state_q == ST_HOLD);

endmodule

// File: doc/parity_step_counter.md
PARITY_STEP_COUNTER -- requirements
Module: parity_step_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the counter width in bits; legal range 2..32.
REQ-002 CLK  input  1  The only clock; all state SHALL update on its rising edge.
REQ-003 RST_N  input  1  Reset, asynchronous and active-low.
REQ-004 EN  input  1  Count enable; one step per enabled cycle.
REQ-005 MODE  input  2  Count mode: 00 even-up, 01 odd-up, 10 even-down, 11 odd-down.
REQ-006 SAT  input  1  End-of-range behaviour: 1 saturates, 0 wraps.
REQ-007 LOAD  input  1  Synchronous load strobe.
REQ-008 LOAD_VAL  input  WIDTH  Value written to OUT on LOAD.
REQ-009 OUT  output  WIDTH  Registered count value.
REQ-010 WRAP  output  1  Registered pulse; high for the one cycle in which OUT holds a value produced by a wrap.
REQ-011 SAT_HIT  output  1  Registered level; high while the counter is held at a saturation bound.

Function
REQ-012 Target parity SHALL be set by MODE[0] (0 even, 1 odd); direction SHALL be set by MODE[1] (0 up, 1 down).
REQ-013 Priority SHALL be RST_N > LOAD > EN; with LOAD=1, EN is ignored that cycle.
REQ-014 LOAD SHALL write LOAD_VAL to OUT unmodified, regardless of its parity, clear WRAP, and clear SAT_HIT.
REQ-015 Parity-aligned step: if EN=1 and OUT parity equals the target parity, the next OUT SHALL be OUT±2.
REQ-016 Realign step: if EN=1 and OUT parity differs from the target parity, the next OUT SHALL be OUT±1.
REQ-017 Bounds SHALL be: even-up max 2^W-2, odd-up max 2^W-1, even-down min 0, odd-down min 1.
REQ-018 Wrap (SAT=0): a step that would cross the bound SHALL continue modulo 2^W, and WRAP SHALL be asserted with the new OUT.
REQ-019 Saturation (SAT=1): a step that would cross the bound SHALL set OUT to that bound, enter state HOLD, and assert SAT_HIT.
REQ-020 The FSM SHALL have two states, RUN and HOLD.
 - RUN to HOLD: the condition in REQ-019.
 - HOLD to RUN: LOAD, a change of MODE, or SAT deasserted.
 - OUT SHALL stay frozen in HOLD.
REQ-021 Leaving HOLD because of a MODE change SHALL take effect on the same enabled cycle, using the new MODE's step.
REQ-022 EN=0 SHALL hold OUT, hold the FSM state and hold SAT_HIT; WRAP SHALL drop after its single cycle.
REQ-023 Realign at a bound: odd-down from 0 SHALL give 2^W-1 with WRAP if SAT=0, or 1 with SAT_HIT if SAT=1.
REQ-024 Realign at a bound: even-up from 2^W-1 SHALL give 0 with WRAP if SAT=0, or 2^W-2 with SAT_HIT if SAT=1.
REQ-025 A MODE or SAT change SHALL take effect on the next rising edge; the count SHALL NOT be interrupted.

Reset
REQ-026 RST_N=0 SHALL immediately force OUT=0, WRAP=0, SAT_HIT=0 and state RUN, with no dependence on CLK.
REQ-027 After RST_N rises, counting SHALL resume from 0 on the first enabled rising edge.

Structure
REQ-028 Package parity_step_counter_pkg SHALL hold the MODE encodings, the FSM state encoding and the bound helper functions.
REQ-029 Sub-module pcnt_next (combinational) SHALL compute next value, wrap flag and saturate flag from OUT, MODE, SAT and WIDTH.
REQ-030 The parent module SHALL own all registers and the FSM.

Verification (WIDTH=3)
REQ-031 Reset, then MODE=00, SAT=0, EN=1 -> OUT 0,2,4,6,0; WRAP=1 only with the final 0.
REQ-032 At OUT=4, switch to MODE=01 -> OUT 5,7,1; WRAP=1 with the 1.
REQ-033 MODE=00, SAT=1 from 0 -> OUT 2,4,6,6,6 with SAT_HIT=1 from the first 6; then MODE=10 -> OUT 4 and SAT_HIT=0.
REQ-034 LOAD=1, LOAD_VAL=3, EN=1 in the same cycle -> OUT=3; then MODE=00 -> 4, 6.
REQ-035 OUT=0, MODE=11: with SAT=0 -> OUT=7 and WRAP=1; rerun with SAT=1 -> OUT=1 and SAT_HIT=1.
REQ-036 RST_N pulsed low between clock edges at OUT=6 -> OUT=0 and flags 0 before the next edge; count then restarts 0,2.
